// File: rtl/regfile_pkg.sv
// regfile_pkg: register-file sizing and mode constants shared with decode and writeback
package regfile_pkg;
  localparam int RF_WIDTH = 16;
  localparam int RF_DEPTH = 8;
  localparam int RF_NREAD = 2;
  localparam bit RF_ZERO_REG = 1'b0;
  localparam bit RF_BYPASS = 1'b1;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy vector, WAW issue stall and registered busy count
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH = RF_DEPTH,
  parameter bit ZERO_REG = RF_ZERO_REG,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             write_en,
  input  logic [AW-1:0]    wreg,
  input  logic             issue_en,
  input  logic [AW-1:0]    issue_reg,
  output logic [DEPTH-1:0] busy,
  output logic             issue_stall,
  output logic [AW:0]      busy_cnt
);
  logic wr_ok, iss_ok;
  logic [DEPTH-1:0] busy_nxt;
  logic [AW:0] cnt_nxt;
  assign issue_stall = issue_en & busy[issue_reg] & ~(write_en & (wreg == issue_reg));
  assign wr_ok = write_en & ~(ZERO_REG & (wreg == '0));
  assign iss_ok = issue_en & ~issue_stall & ~(ZERO_REG & (issue_reg == '0));
  // set is applied after clear so a same-register issue wins over writeback
  assign busy_nxt = (busy & ~(DEPTH'(wr_ok) << wreg)) | (DEPTH'(iss_ok) << issue_reg);
  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) cnt_nxt += (AW+1)'(busy_nxt[i]);
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy <= '0;
      busy_cnt <= '0;
    end else begin
      busy <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with write bypass and busy scoreboard
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int WIDTH = RF_WIDTH,
  parameter int DEPTH = RF_DEPTH,
  parameter int NREAD = RF_NREAD,
  parameter bit ZERO_REG = RF_ZERO_REG,
  parameter bit BYPASS = RF_BYPASS,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   write_en,
  input  logic [AW-1:0]          wreg,
  input  logic [WIDTH-1:0]       writedata,
  input  logic [NREAD*AW-1:0]    rd_addr,
  output logic [NREAD*WIDTH-1:0] rd_data,
  output logic [NREAD-1:0]       rd_busy,
  input  logic                   issue_en,
  input  logic [AW-1:0]          issue_reg,
  output logic                   issue_stall,
  output logic [AW:0]            busy_cnt
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] busy;
  always_ff @(posedge clk) begin
    if (!reset_n) mem <= '{default: '0};
    else if (write_en && !(ZERO_REG && wreg == '0)) mem[wreg] <= writedata;
  end
  for (genvar g = 0; g < NREAD; g++) begin : g_rd
    logic [AW-1:0] a;
    logic hit;
    assign a = rd_addr[g*AW +: AW];
    assign hit = BYPASS && write_en && reset_n && (wreg == a);
    assign rd_data[g*WIDTH +: WIDTH] = (ZERO_REG && a == '0) ? '0 : hit ? writedata : mem[a];
    assign rd_busy[g] = busy[a] & ~hit;
  end
  regfile_scoreboard #(.DEPTH(DEPTH), .ZERO_REG(ZERO_REG)) u_sb (
    .clk(clk),
    .reset_n(reset_n),
    .write_en(write_en),
    .wreg(wreg),
    .issue_en(issue_en),
    .issue_reg(issue_reg),
    .busy(busy),
    .issue_stall(issue_stall),
    .busy_cnt(busy_cnt)
  );
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: three 8x16 variants checked against an array model, plus a 16x32 three-port sweep
module tb_regfile_sb;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic we = 1'b0, ie = 1'b0;
  logic [2:0] wreg = '0, ir = '0;
  logic [15:0] wd = '0;
  logic [5:0] rd_addr = '0;
  logic [31:0] d_data [3];
  logic [1:0] d_busy [3];
  logic d_stall [3];
  logic [3:0] d_cnt [3];
  logic b_we = 1'b0, b_ie = 1'b0;
  logic [3:0] b_wreg = '0, b_ir = '0;
  logic [31:0] b_wd = '0;
  logic [11:0] b_rd_addr = '0;
  logic [95:0] b_rd_data;
  logic [2:0] b_rd_busy;
  logic b_stall;
  logic [4:0] b_cnt;
  int nchk = 0, nerr = 0;
  localparam bit ZR [3] = '{1'b0, 1'b0, 1'b1};
  localparam bit BYP [3] = '{1'b1, 1'b0, 1'b1};
  logic [15:0] m_mem [3][8];
  bit m_busy [3][8];
  always #5 clk = ~clk;
  regfile_sb u_def (.clk(clk), .reset_n(reset_n), .write_en(we), .wreg(wreg), .writedata(wd),
    .rd_addr(rd_addr), .rd_data(d_data[0]), .rd_busy(d_busy[0]), .issue_en(ie), .issue_reg(ir),
    .issue_stall(d_stall[0]), .busy_cnt(d_cnt[0]));
  regfile_sb #(.BYPASS(1'b0)) u_nb (.clk(clk), .reset_n(reset_n), .write_en(we), .wreg(wreg),
    .writedata(wd), .rd_addr(rd_addr), .rd_data(d_data[1]), .rd_busy(d_busy[1]), .issue_en(ie),
    .issue_reg(ir), .issue_stall(d_stall[1]), .busy_cnt(d_cnt[1]));
  regfile_sb #(.ZERO_REG(1'b1)) u_zr (.clk(clk), .reset_n(reset_n), .write_en(we), .wreg(wreg),
    .writedata(wd), .rd_addr(rd_addr), .rd_data(d_data[2]), .rd_busy(d_busy[2]), .issue_en(ie),
    .issue_reg(ir), .issue_stall(d_stall[2]), .busy_cnt(d_cnt[2]));
  regfile_sb #(.WIDTH(32), .DEPTH(16), .NREAD(3)) u_big (.clk(clk), .reset_n(reset_n),
    .write_en(b_we), .wreg(b_wreg), .writedata(b_wd), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
    .rd_busy(b_rd_busy), .issue_en(b_ie), .issue_reg(b_ir), .issue_stall(b_stall),
    .busy_cnt(b_cnt));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic int pop(input int k);
    int n = 0;
    for (int r = 0; r < 8; r++) n += int'(m_busy[k][r]);
    return n;
  endfunction
  task automatic settle();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      for (int p = 0; p < 2; p++) begin
        logic [2:0] a;
        bit hit;
        logic [15:0] ed;
        a = rd_addr[p*3 +: 3];
        hit = BYP[k] && we && reset_n && wreg == a;
        ed = (ZR[k] && a == 0) ? 16'h0 : hit ? wd : m_mem[k][a];
        chk($sformatf("rd_data[%0d].%0d", k, p), 32'(d_data[k][p*16 +: 16]), 32'(ed));
        chk($sformatf("rd_busy[%0d].%0d", k, p), 32'(d_busy[k][p]), 32'(m_busy[k][a] && !hit));
      end
      chk($sformatf("issue_stall[%0d]", k), 32'(d_stall[k]),
          32'(ie && m_busy[k][ir] && !(we && wreg == ir)));
      chk($sformatf("busy_cnt[%0d]", k), 32'(d_cnt[k]), 32'(pop(k)));
    end
  endtask
  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (!reset_n) begin
        for (int r = 0; r < 8; r++) begin
          m_mem[k][r] = '0;
          m_busy[k][r] = 1'b0;
        end
      end else begin
        bit st;
        st = ie && m_busy[k][ir] && !(we && wreg == ir);
        if (we && !(ZR[k] && wreg == 0)) begin
          m_mem[k][wreg] = wd;
          m_busy[k][wreg] = 1'b0;
        end
        if (ie && !st && !(ZR[k] && ir == 0)) m_busy[k][ir] = 1'b1;
      end
    end
    #1;
  endtask
  function automatic logic [31:0] bval(input int r);
    return 32'hC0DE_0000 + 32'(r) * 32'h0000_0101;
  endfunction
  initial begin
    tick();
    reset_n = 1'b1;
    settle();
    chk("reset_cnt", 32'(d_cnt[0]), 32'd0);
    tick();
    we = 1'b1; wreg = 3'd3; wd = 16'hBEEF;
    settle(); tick();
    we = 1'b0; rd_addr = 6'd3;
    settle();
    chk("r3_written", 32'(d_data[0][15:0]), 32'h0000_BEEF);
    tick();
    reset_n = 1'b0; we = 1'b1; wreg = 3'd3; wd = 16'h1111; ie = 1'b1; ir = 3'd3;
    settle(); tick();
    reset_n = 1'b1; we = 1'b0; ie = 1'b0;
    settle();
    chk("r3_after_reset", 32'(d_data[0][15:0]), 32'h0);
    chk("busy_after_reset", 32'(d_busy[0][0]), 32'h0);
    chk("cnt_after_reset", 32'(d_cnt[0]), 32'h0);
    tick();
    we = 1'b1; wreg = 3'd1; wd = 16'h1234; rd_addr = 6'd1;
    settle();
    chk("bypass_hit", 32'(d_data[0][15:0]), 32'h1234);
    chk("nobypass_old", 32'(d_data[1][15:0]), 32'h0);
    tick();
    we = 1'b0;
    settle();
    chk("nobypass_next", 32'(d_data[1][15:0]), 32'h1234);
    tick();
    ie = 1'b1; ir = 3'd5; rd_addr = 6'd5;
    settle();
    chk("first_issue_stall", 32'(d_stall[0]), 32'h0);
    tick();
    settle();
    chk("r5_busy", 32'(d_busy[0][0]), 32'h1);
    chk("cnt_one", 32'(d_cnt[0]), 32'h1);
    chk("reissue_stall", 32'(d_stall[0]), 32'h1);
    tick();
    ie = 1'b0;
    settle();
    chk("cnt_still_one", 32'(d_cnt[0]), 32'h1);
    tick();
    we = 1'b1; wreg = 3'd5; wd = 16'h00AA;
    settle(); tick();
    we = 1'b0;
    settle();
    chk("r5_released", 32'(d_busy[0][0]), 32'h0);
    chk("cnt_zero", 32'(d_cnt[0]), 32'h0);
    chk("r5_data", 32'(d_data[0][15:0]), 32'h00AA);
    tick();
    ie = 1'b1; ir = 3'd2;
    settle(); tick();
    we = 1'b1; wreg = 3'd2; wd = 16'h5A5A;
    settle();
    chk("wr_iss_stall", 32'(d_stall[0]), 32'h0);
    tick();
    we = 1'b0; ie = 1'b0; rd_addr = 6'd2;
    settle();
    chk("wr_iss_data", 32'(d_data[0][15:0]), 32'h5A5A);
    chk("wr_iss_busy", 32'(d_busy[0][0]), 32'h1);
    chk("wr_iss_cnt", 32'(d_cnt[0]), 32'h1);
    tick();
    we = 1'b1; wreg = 3'd2;
    settle(); tick();
    wreg = 3'd0; wd = 16'hFFFF; ie = 1'b1; ir = 3'd0; rd_addr = 6'd0;
    settle();
    chk("zr_stall", 32'(d_stall[2]), 32'h0);
    chk("zr_read_same", 32'(d_data[2][15:0]), 32'h0);
    tick();
    we = 1'b0;
    settle();
    chk("zr_read", 32'(d_data[2][15:0]), 32'h0);
    chk("zr_busy", 32'(d_busy[2][0]), 32'h0);
    chk("zr_cnt", 32'(d_cnt[2]), 32'h0);
    chk("zr_reissue", 32'(d_stall[2]), 32'h0);
    tick();
    for (int n = 0; n < 400; n++) begin
      reset_n = ($urandom_range(0, 31) != 0);
      we = 1'($urandom_range(0, 1));
      ie = 1'($urandom_range(0, 1));
      wreg = 3'($urandom_range(0, 7));
      ir = 3'($urandom_range(0, 7));
      wd = 16'($urandom);
      rd_addr = 6'($urandom_range(0, 63));
      settle(); tick();
    end
    reset_n = 1'b0; we = 1'b0; ie = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int r = 0; r < 16; r++) begin
      b_we = 1'b1; b_wreg = 4'(r); b_wd = bval(r);
      tick();
    end
    b_we = 1'b0;
    for (int r = 0; r < 16; r++) begin
      for (int p = 0; p < 3; p++) b_rd_addr[p*4 +: 4] = 4'((r + p) % 16);
      settle();
      for (int p = 0; p < 3; p++)
        chk($sformatf("big_rd%0d_r%0d", p, (r + p) % 16), b_rd_data[p*32 +: 32], bval((r + p) % 16));
      tick();
    end
    for (int r = 0; r < 16; r++) begin
      b_ie = 1'b1; b_ir = 4'(r);
      settle();
      chk($sformatf("big_issue_r%0d", r), 32'(b_stall), 32'h0);
      tick();
    end
    b_ir = 4'd7;
    settle();
    chk("big_cnt_full", 32'(b_cnt), 32'd16);
    chk("big_busy_all", 32'(b_rd_busy), 32'h7);
    chk("big_full_stall", 32'(b_stall), 32'h1);
    tick();
    b_ie = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised, scoreboarded register file for the 16-bit CPU datapath; next generation of the 8×16, 2-read/1-write register file. Adds configurable width, depth and read-port count, synchronous clear, optional hard-wired zero register, and write-to-read bypass. Adds a per-register busy scoreboard that the issue stage sets and writeback clears. Sits between decode/issue (read and reserve) and writeback (write and release).

## Interface
- `WIDTH`, 16: data width in bits.
- `DEPTH`, 8: number of registers; power of two, ≥ 2.
- `AW`, $clog2(DEPTH): register address width (derived, do not override).
- `NREAD`, 2: number of read ports, 1–4.
- `ZERO_REG`, 0: if 1, register 0 always reads 0, ignores writes, and is never busy.
- `BYPASS`, 1: if 1, same-cycle write data is forwarded to matching read ports.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `write_en` in 1: writeback strobe.
- `wreg` in AW: writeback register address.
- `writedata` in WIDTH: writeback data.
- `rd_addr` in NREAD*AW: packed read addresses; port i is at [i*AW +: AW].
- `rd_data` out NREAD*WIDTH: packed read data; port i is at [i*WIDTH +: WIDTH].
- `rd_busy` out NREAD: busy bit of each addressed register.
- `issue_en` in 1: reserve request for a destination register.
- `issue_reg` in AW: destination register to reserve.
- `issue_stall` out 1: the reserve request is rejected this cycle.
- `busy_cnt` out AW+1: number of registers currently busy.

## Operation
- **Storage:** DEPTH×WIDTH flops and a DEPTH-bit busy vector.
- **Reset:** edge with reset_n=0 sets all registers to 0, clears all busy bits and sets busy_cnt to 0. Writes and issues presented in that cycle are discarded.
- **Write:** edge with write_en=1 stores writedata into wreg and clears busy[wreg]. With ZERO_REG=1 and wreg=0, nothing happens.
- **Read:** combinational, for each port i.
  - ZERO_REG=1 and rd_addr_i=0 → rd_data_i=0.
  - Else, BYPASS=1, write_en=1, wreg=rd_addr_i and reset_n=1 → rd_data_i=writedata.
  - Else → stored value.
- **rd_busy_i:** equals busy[rd_addr_i], masked to 0 when the bypass hit above applies (the data is valid that cycle).
- **Issue:** issue_stall = issue_en & busy[issue_reg] & ~(write_en & wreg==issue_reg). This blocks a WAW hazard unless writeback releases the register in the same cycle. If issue_en=1 and issue_stall=0, the edge sets busy[issue_reg].
  - With ZERO_REG=1, issue_reg=0: accepted, never stalls, busy is not set.
- **Simultaneous write and issue, same register:** the issue wins, so busy ends at 1 and writedata is still stored.
- **busy_cnt:** registered population count of the busy vector, updated on the same edge as the vector. Net change per edge is −1, 0 or +1.

## Timing
- Read latency: 0 cycles (combinational). Write is visible through storage from the cycle after the edge, and the same cycle via bypass.
- Busy set or clear takes effect at the edge; rd_busy and busy_cnt reflect it in the following cycle.
- issue_stall is combinational, valid in the same cycle as issue_en.
- Reset asserted mid-operation: the next edge clears everything regardless of write_en or issue_en. All outputs read 0 from the first cycle after that edge.
- Out-of-range addresses are not possible; DEPTH is a power of two.

## Structure
- Package `regfile_pkg`: default WIDTH/DEPTH/NREAD constants and the `RF_ZERO_REG` / `RF_BYPASS` mode constants, shared with decode and writeback.
- One sub-module, `regfile_scoreboard`: busy vector, stall logic and busy_cnt, parametrised by DEPTH and ZERO_REG.
- Storage and the read/bypass mux stay in `regfile_sb`.

## Test plan
All scenarios use defaults unless stated.
- **Reset:** write 16'hBEEF to r3, then hold reset_n=0 for one edge → rd_data for r3 = 0, rd_busy=0, busy_cnt=0. A write presented during reset is lost.
- **Write/read and bypass:** write 16'h1234 to r1 while port 0 reads r1 → same-cycle rd_data0=16'h1234. With BYPASS=0 the same stimulus shows the old value 0, then 16'h1234 the next cycle.
- **Scoreboard:** issue r5 → rd_busy=1 and busy_cnt=1. Issue r5 again → issue_stall=1 and busy_cnt stays 1. Write r5 with 16'h00AA → busy cleared, busy_cnt=0.
- **Simultaneous events:** r2 busy, then write r2 and issue r2 in the same cycle → issue_stall=0, r2 = write value, busy[r2]=1, busy_cnt unchanged at 1.
- **Zero register:** ZERO_REG=1, write 16'hFFFF to r0 and issue r0 → reads 0, never busy, busy_cnt=0.
- **Width/depth sweep:** WIDTH=32, DEPTH=16, NREAD=3. Write a distinct value to each register, then read all on three ports simultaneously → every port returns the matching value. Fill the scoreboard to busy_cnt=16.
